// File: rtl/dmem_responder.sv
// Word-wide data-memory responder that serves each request over one 8-bit asynchronous SRAM, one byte lane at a time.
// Build option: define DMEM_WAIT_EN to stretch every strobe by WAIT_CYC extra cycles for slow SRAM parts.
module dmem_responder #(
    parameter int ADDR_W   = 17,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be_n,
    input  logic              req_we_n,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    inout  wire  [7:0]        sram_dq
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-3:0] word_addr;
    logic              is_store;
    logic [31:0]       wdata;
    logic [3:0]        mask;
    logic [1:0]        lane;
    logic [7:0]        dq_out;
    logic              dq_en;

    logic [3:0]        req_mask;
    logic [1:0]        first_lane;
    logic [3:0]        rest_mask;
    logic [1:0]        next_lane;
    logic              strobe_done;
    logic              unused_bits;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        logic [1:0] l;
        if (m[0])      l = 2'd0;
        else if (m[1]) l = 2'd1;
        else if (m[2]) l = 2'd2;
        else           l = 2'd3;
        return l;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign req_mask   = ~req_be_n;
    assign first_lane = low_lane(req_mask);
    assign rest_mask  = mask & ~(4'b0001 << lane);
    assign next_lane  = low_lane(rest_mask);

    // The SRAM bus is only driven while a store owns it; everywhere else the chip may drive it.
    assign sram_dq = dq_en ? dq_out : 8'bz;

    // Byte-address bits [1:0] are meaningless for a word port, and WAIT_CYC only matters with the wait option.
    assign unused_bits = ^{req_addr[1:0], 32'(WAIT_CYC)};

`ifdef DMEM_WAIT_EN
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Reloaded while the address settles, then counts down across the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= CNT_W'(WAIT_CYC);
        end else if (state == STROBE && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign strobe_done = (wait_cnt == '0);
`else
    assign strobe_done = 1'b1;
`endif

    // All SRAM controls are registered and loaded on the edge that enters each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            word_addr  <= '0;
            is_store   <= 1'b0;
            wdata      <= '0;
            mask       <= '0;
            lane       <= '0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            dq_out     <= '0;
            dq_en      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!req_ready) begin
                        // A zero-lane request was taken on the previous edge; answer it now.
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        word_addr  <= req_addr[ADDR_W-1:2];
                        is_store   <= ~req_we_n;
                        wdata      <= req_wdata;
                        mask       <= req_mask;
                        if (req_mask != 4'b0000) begin
                            state     <= SETUP;
                            lane      <= first_lane;
                            sram_addr <= {req_addr[ADDR_W-1:2], first_lane};
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= ~req_we_n;
                            sram_we_n <= 1'b1;
                            dq_out    <= lane_byte(req_wdata, first_lane);
                            dq_en     <= ~req_we_n;
                        end
                    end
                end

                SETUP: begin
                    state     <= STROBE;
                    sram_we_n <= ~is_store;
                end

                STROBE: begin
                    if (strobe_done) begin
                        state     <= HOLD;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!is_store) begin
                            resp_rdata[{lane, 3'b000} +: 8] <= sram_dq;
                        end
                    end
                end

                HOLD: begin
                    mask <= rest_mask;
                    if (rest_mask == 4'b0000) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        dq_en      <= 1'b0;
                    end else begin
                        state     <= SETUP;
                        lane      <= next_lane;
                        sram_addr <= {word_addr, next_lane};
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= is_store;
                        sram_we_n <= 1'b1;
                        dq_out    <= lane_byte(wdata, next_lane);
                        dq_en     <= is_store;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with a behavioural byte-wide asynchronous SRAM model.
// Latencies follow the DMEM_WAIT_EN build option with the default WAIT_CYC.
module tb_dmem_responder;

    localparam int ADDR_W = 17;
`ifdef DMEM_WAIT_EN
    localparam int LANE_CYC = 4;
`else
    localparam int LANE_CYC = 3;
`endif

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be_n;
    logic              req_we_n;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    wire  [7:0]        sram_dq;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    exp_t       exp_q[$];
    int         cycle;
    int         we_pulses;
    int         ce_falls;
    int         checks_total;
    int         checks_passed;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_be_n   (req_be_n),
        .req_we_n   (req_we_n),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_addr  (sram_addr),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_dq    (sram_dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // SRAM model: reads while selected and output-enabled, writes on the rising edge of we_n.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 8'bz;

    always @(posedge sram_we_n) if (!sram_ce_n) mem[sram_addr] <= sram_dq;
    always @(negedge sram_we_n) we_pulses <= we_pulses + 1;
    always @(negedge sram_ce_n) ce_falls <= ce_falls + 1;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i) ^ 8'h5A;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic report_fail(input string name, input string msg);
        checks_total++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic [3:0] be_n, input logic we_n,
                                  input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_lat,
                                  input bit expect_resp);
        bit accepted;
        @(posedge clk);
        #2;
        req_addr  = addr;
        req_be_n  = be_n;
        req_we_n  = we_n;
        req_wdata = wdata;
        req_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                if (expect_resp) exp_q.push_back('{exp_rdata, exp_lat, cycle + 1});
            end
        end
        if (!accepted) report_fail("accept", "request never accepted within 200 cycles");
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !resp_valid) done = 1'b1;
        end
        if (!done) report_fail("drain", "responses still outstanding after 400 cycles");
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks data, latency and hold.
    initial begin : monitor
        bit          seen;
        logic [31:0] held;
        int          first_cyc;
        exp_t        e;
        seen = 1'b0;
        held = '0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (!seen) begin
                    seen      = 1'b1;
                    held      = resp_rdata;
                    first_cyc = cycle;
                end else begin
                    check_output("rdata_hold", resp_rdata, held);
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        report_fail("unexpected_resp", $sformatf("response 0x%08h with empty scoreboard", resp_rdata));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("resp_rdata", resp_rdata, e.rdata);
                        check_output("latency", 32'(first_cyc - e.acc), 32'(e.lat));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int wp;
        int cf;
        bit got;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_be_n   = 4'hF;
        req_we_n   = 1'b1;
        req_wdata  = '0;
        resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_output("rst_req_ready", req_ready, 1);
        check_output("rst_resp_valid", resp_valid, 0);
        check_output("rst_resp_rdata", resp_rdata, 0);
        check_output("rst_ce_n", sram_ce_n, 1);
        check_output("rst_oe_n", sram_oe_n, 1);
        check_output("rst_we_n", sram_we_n, 1);
        check_output("rst_addr", 32'(sram_addr), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        wp = we_pulses;
        apply_stimulus(17'h00010, 4'b0000, 1'b0, 32'hDEADBEEF, 32'h0, 4 * LANE_CYC, 1'b1);
        wait_drain();
        check_output("store_we_pulses", 32'(we_pulses - wp), 4);
        check_output("store_sram_word", {mem[17'h13], mem[17'h12], mem[17'h11], mem[17'h10]}, 32'hDEADBEEF);

        apply_stimulus(17'h00010, 4'b0000, 1'b1, 32'h0, 32'hDEADBEEF, 4 * LANE_CYC, 1'b1);
        wait_drain();

        apply_stimulus(17'h00010, 4'b0110, 1'b1, 32'h0, 32'hDE0000EF, 2 * LANE_CYC, 1'b1);
        wait_drain();

        wp = we_pulses;
        apply_stimulus(17'h00020, 4'b1010, 1'b0, 32'h11223344, 32'h0, 2 * LANE_CYC, 1'b1);
        wait_drain();
        check_output("sparse_we_pulses", 32'(we_pulses - wp), 2);
        check_output("sparse_sram_word", {mem[17'h23], mem[17'h22], mem[17'h21], mem[17'h20]}, 32'h79227B44);

        apply_stimulus(17'h00020, 4'b0000, 1'b1, 32'h0, 32'h79227B44, 4 * LANE_CYC, 1'b1);
        wait_drain();

        cf = ce_falls;
        apply_stimulus(17'h00030, 4'b1111, 1'b1, 32'h0, 32'h0, 1, 1'b1);
        wait_drain();
        check_output("zero_lane_ce_idle", 32'(ce_falls - cf), 0);

        // Backpressure: hold the response while a new request waits at the input.
        @(posedge clk);
        #2;
        resp_ready = 1'b0;
        apply_stimulus(17'h00010, 4'b0000, 1'b1, 32'h0, 32'hDEADBEEF, 4 * LANE_CYC, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        if (!got) report_fail("bp_resp", "response never became valid");
        @(posedge clk);
        #2;
        req_addr  = 17'h00020;
        req_be_n  = 4'b1110;
        req_we_n  = 1'b1;
        req_wdata = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_resp_valid", resp_valid, 1);
            check_output("bp_req_ready", req_ready, 0);
            check_output("bp_rdata", resp_rdata, 32'hDEADBEEF);
            @(posedge clk);
            #2;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_no_early_accept", req_ready, 0);
        @(negedge clk);
        check_output("bp_ready_after", req_ready, 1);
        exp_q.push_back('{32'h00000044, LANE_CYC, cycle + 1});
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        wait_drain();

        // Reset in the middle of the lane-2 strobe of a store.
        apply_stimulus(17'h00040, 4'b0000, 1'b0, 32'hCAFEF00D, 32'h0, 0, 1'b0);
        repeat (2 * LANE_CYC + 1) @(posedge clk);
        #2;
        check_output("pre_reset_we_n", sram_we_n, 0);
        check_output("pre_reset_addr", 32'(sram_addr), 32'h00042);
        rst = 1'b1;
        #1;
        check_output("mid_rst_we_n", sram_we_n, 1);
        check_output("mid_rst_ce_n", sram_ce_n, 1);
        check_output("mid_rst_oe_n", sram_oe_n, 1);
        check_output("mid_rst_resp_valid", resp_valid, 0);
        check_output("mid_rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_kept_bytes", {16'h0, mem[17'h41], mem[17'h40]}, 32'h0000F00D);
        apply_stimulus(17'h00040, 4'b1100, 1'b1, 32'h0, 32'h0000F00D, 2 * LANE_CYC, 1'b1);
        wait_drain();

        check_output("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
